// File: rtl/rtc_pkg.sv
// rtc_pkg: shared FSM encoding, default parameters and RTC register map.
package rtc_pkg;
  localparam int DATA_W_DEF    = 8;
  localparam int MAX_BURST_DEF = 16;
  localparam int T_PHASE_DEF   = 4;
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDR      = 3'd1;
  localparam logic [2:0] S_ADDR_HOLD = 3'd2;
  localparam logic [2:0] S_DATA      = 3'd3;
  localparam logic [2:0] S_DATA_HOLD = 3'd4;
  localparam logic [7:0] RTC_SECONDS  = 8'h00;
  localparam logic [7:0] RTC_MINUTES  = 8'h02;
  localparam logic [7:0] RTC_HOURS    = 8'h04;
  localparam logic [7:0] RTC_WEEKDAY  = 8'h06;
  localparam logic [7:0] RTC_DAY      = 8'h07;
  localparam logic [7:0] RTC_MONTH    = 8'h08;
  localparam logic [7:0] RTC_YEAR     = 8'h09;
  localparam logic [7:0] RTC_TIMER_LO = 8'h0A;
  localparam logic [7:0] RTC_TIMER_HI = 8'h0B;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: down-counter reloaded with T_PHASE-1, flags the last cycle of each bus phase.
module phase_timer #(
  parameter int T_PHASE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic phase_end
);
  localparam logic [7:0] RELOAD = 8'(T_PHASE - 1);
  logic [7:0] cnt_q, cnt_d;
  assign phase_end = run && (cnt_q == 8'd0);
  always_comb cnt_d = (!run || cnt_q == 8'd0) ? RELOAD : cnt_q - 8'd1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= RELOAD;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: multiplexed address/data RTC bus master running read or write bursts.
module rtc_bus_sequencer
  import rtc_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int T_PHASE   = T_PHASE_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           op,
  input  logic [DATA_W-1:0]              base_addr,
  input  logic [$clog2(MAX_BURST+1)-1:0] count,
  input  logic [DATA_W-1:0]              wdata,
  input  logic [DATA_W-1:0]              dato_in,
  output logic [DATA_W-1:0]              dato_out,
  output logic                           dato_oe,
  output logic                           a_d,
  output logic                           cs,
  output logic                           rd,
  output logic                           wr,
  output logic                           wdata_req,
  output logic [DATA_W-1:0]              rdata,
  output logic                           rdata_valid,
  output logic [$clog2(MAX_BURST)-1:0]   word_idx,
  output logic                           busy,
  output logic                           done
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(MAX_BURST);
  logic [2:0]        state_q, state_d;
  logic              op_q, op_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] wword_q, wword_d;
  logic              first_q, first_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              done_q, done_d;
  logic              phase_end, count_ok, last_word, addr_ph, data_ph, cap;
  phase_timer #(.T_PHASE(T_PHASE)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .run      (busy),
    .phase_end(phase_end)
  );
  assign busy      = state_q != S_IDLE;
  assign count_ok  = (count != '0) && (32'(count) <= MAX_BURST);
  assign last_word = (32'(idx_q) + 1) == 32'(cnt_q);
  assign addr_ph   = (state_q == S_ADDR) || (state_q == S_ADDR_HOLD);
  assign data_ph   = (state_q == S_DATA) || (state_q == S_DATA_HOLD);
  assign cap       = (state_q == S_DATA) && phase_end && !op_q;
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wword_d  = first_q ? wdata : wword_q;
    first_d  = wdata_req;
    rdata_d  = cap ? dato_in : rdata_q;
    rvalid_d = cap;
    done_d   = 1'b0;
    if (state_q == S_IDLE) begin
      if (start && count_ok) begin
        state_d = S_ADDR;
        op_d    = op;
        addr_d  = base_addr;
        cnt_d   = count;
        idx_d   = '0;
      end
      done_d = start && !count_ok;
    end else if (phase_end) begin
      state_d = (state_q == S_ADDR) ? S_ADDR_HOLD :
                (state_q == S_ADDR_HOLD) ? S_DATA :
                (state_q == S_DATA) ? S_DATA_HOLD :
                last_word ? S_IDLE : S_ADDR;
      if (state_q == S_DATA_HOLD && !last_word) begin
        addr_d = addr_q + DATA_W'(1);
        idx_d  = idx_q + IW'(1);
      end
      done_d = (state_q == S_DATA_HOLD) && last_word;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      wword_q  <= '0;
      first_q  <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wword_q  <= wword_d;
      first_q  <= first_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
    end
  // The first DATA cycle forwards wdata directly since the word is only latched at its end.
  assign wdata_req   = (state_q == S_ADDR_HOLD) && phase_end && op_q;
  assign a_d         = state_q != S_ADDR;
  assign cs          = !((state_q == S_ADDR) || (state_q == S_DATA));
  assign rd          = !((state_q == S_DATA) && !op_q);
  assign wr          = !((state_q == S_ADDR) || ((state_q == S_DATA) && op_q));
  assign dato_oe     = addr_ph || (data_ph && op_q);
  assign dato_out    = addr_ph ? addr_q : (data_ph && op_q) ? (first_q ? wdata : wword_q) : '0;
  assign rdata       = rdata_q;
  assign rdata_valid = rvalid_q;
  assign word_idx    = idx_q;
  assign done        = done_q;
endmodule
